// File: rtl/fetch_queue.sv
// fetch_queue: credit-limited instruction fetch front end with an in-order
// response queue and redirect flush that drops late responses.
module fetch_queue #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    output logic                  imem_req_valid_o,
    input  logic                  imem_req_ready_i,
    output logic [DATA_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_rsp_valid_i,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data_i,
    output logic                  instr_valid_o,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [DATA_WIDTH-1:0] instr_pc_o,
    input  logic                  instr_ready_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;

    state_t                  state;
    logic                    started;
    logic [DATA_WIDTH-1:0]   fetch_pc, rsp_pc, rpc;
    logic [CW-1:0]           outst, occ, disc, outst_nxt;
    logic [AW-1:0]           head, tail;
    logic [DATA_WIDTH-1:0]   mem_d [DEPTH];
    logic [DATA_WIDTH-1:0]   mem_p [DEPTH];
    logic                    acc, pop, keep, flush;

    assign imem_req_valid_o = (state == FETCH) && (({1'b0, outst} + {1'b0, occ}) < (CW + 1)'(DEPTH));
    assign imem_addr_o      = fetch_pc;
    assign instr_valid_o    = occ != '0;
    assign instr_o          = mem_d[head];
    assign instr_pc_o       = mem_p[head];
    assign acc              = imem_req_valid_o && imem_req_ready_i;
    assign pop              = instr_valid_o && instr_ready_i;
    assign flush            = redirect_i && state != IDLE;
    assign keep             = imem_rsp_valid_i && disc == '0 && !flush;
    assign rpc              = redirect_pc_i & ~DATA_WIDTH'(3);
    // Everything still in flight after this cycle is stale once a redirect lands.
    assign outst_nxt        = outst + CW'(acc) - CW'(imem_rsp_valid_i);

    always_ff @(posedge clk) begin
        if (keep) begin
            mem_d[tail] <= imem_rsp_data_i;
            mem_p[tail] <= rsp_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            started  <= 1'b0;
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            outst    <= '0;
            occ      <= '0;
            disc     <= '0;
            head     <= '0;
            tail     <= '0;
        end else begin
            started <= started | start_i;
            outst   <= outst_nxt;
            if (flush) begin
                fetch_pc <= rpc;
                rsp_pc   <= rpc;
                occ      <= '0;
                head     <= '0;
                tail     <= '0;
                disc     <= outst_nxt;
                state    <= outst_nxt != '0 ? FLUSH : FETCH;
            end else begin
                if (acc) fetch_pc <= fetch_pc + DATA_WIDTH'(4);
                if (keep) begin
                    rsp_pc <= rsp_pc + DATA_WIDTH'(4);
                    tail   <= tail + 1'b1;
                end
                if (pop) head <= head + 1'b1;
                occ <= occ + CW'(keep) - CW'(pop);
                if (imem_rsp_valid_i && disc != '0) disc <= disc - 1'b1;
                state <= state == IDLE ? ((start_i || started) ? FETCH : IDLE) :
                         (state == FLUSH && imem_rsp_valid_i && disc == CW'(1)) ? FETCH : state;
            end
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and random stimulus against a queue-based
// behavioural model of the fetch front end and its instruction memory.
module tb_fetch_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i = 1'b0;
    logic [31:0] imem_addr_o;
    logic        imem_rsp_valid_i = 1'b0;
    logic [31:0] imem_rsp_data_i = '0;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;

    fetch_queue dut (
        .clk(clk), .rst(rst), .start_i(start_i),
        .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(imem_req_ready_i),
        .imem_addr_o(imem_addr_o), .imem_rsp_valid_i(imem_rsp_valid_i),
        .imem_rsp_data_i(imem_rsp_data_i), .instr_valid_o(instr_valid_o),
        .instr_o(instr_o), .instr_pc_o(instr_pc_o), .instr_ready_i(instr_ready_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total = 0;
    int acc_cnt = 0;

    // Model: in-flight beats carry a drop flag; the queue holds {instr, pc}.
    bit          active;
    bit          infl[$];
    logic [31:0] mq[$];
    logic [31:0] fq_d[$];
    logic [31:0] fq_p[$];
    logic [31:0] m_fpc, m_rpc;

    function automatic logic [31:0] h(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        active = 0;
        infl.delete();
        mq.delete();
        fq_d.delete();
        fq_p.delete();
        m_fpc = 32'h0;
        m_rpc = 32'h0;
    endtask

    task automatic step(input logic st, input logic rdy, input logic rsp_en, input logic ird,
                        input logic rd, input logic [31:0] rpc);
        bit flushing, exp_rv, acc, pop, rsp, d;
        logic [31:0] mdata;
        flushing = 0;
        foreach (infl[i]) if (infl[i]) flushing = 1;
        exp_rv = active && !flushing && (infl.size() + fq_d.size() < DEPTH);
        chk("req_valid", imem_req_valid_o, exp_rv);
        if (exp_rv) chk("req_addr", imem_addr_o, m_fpc);
        chk("instr_valid", instr_valid_o, fq_d.size() != 0);
        if (fq_d.size() != 0) begin
            chk("instr", instr_o, fq_d[0]);
            chk("instr_pc", instr_pc_o, fq_p[0]);
        end
        if (imem_req_valid_o && rdy) acc_cnt++;
        rsp = rsp_en && mq.size() != 0;
        start_i = st;
        imem_req_ready_i = rdy;
        imem_rsp_valid_i = rsp;
        imem_rsp_data_i = rsp ? h(mq[0]) : $urandom;
        instr_ready_i = ird;
        redirect_i = rd;
        redirect_pc_i = rpc;
        acc = exp_rv && rdy;
        pop = fq_d.size() != 0 && ird;
        d = 0;
        mdata = '0;
        if (rsp) begin
            d = infl.pop_front();
            mdata = h(mq.pop_front());
        end
        if (acc) mq.push_back(m_fpc);
        if (rd && active) begin
            fq_d.delete();
            fq_p.delete();
            foreach (infl[i]) infl[i] = 1;
            if (acc) infl.push_back(1);
            m_fpc = rpc & ~32'h3;
            m_rpc = rpc & ~32'h3;
        end else begin
            if (pop) begin
                void'(fq_d.pop_front());
                void'(fq_p.pop_front());
            end
            if (rsp && !d) begin
                fq_d.push_back(mdata);
                fq_p.push_back(m_rpc);
                m_rpc += 4;
            end
            if (acc) begin
                infl.push_back(0);
                m_fpc += 4;
            end
        end
        if (st) active = 1;
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        repeat (n) step(0, 0, 1, 1, 0, 0);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_req_valid", imem_req_valid_o, 0);
        chk("rst_instr_valid", instr_valid_o, 0);
        chk("rst_addr", imem_addr_o, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        repeat (3) step(0, 1, 1, 1, 1, 32'h40);
        chk("idle_no_req", imem_req_valid_o, 0);

        step(1, 1, 1, 1, 0, 0);
        for (int k = 0; k < 10; k++) begin
            chk("seq_valid", imem_req_valid_o, 1);
            chk("seq_addr", imem_addr_o, 32'(4 * k));
            if (k >= 2) chk("seq_pc", instr_pc_o, 32'(4 * (k - 2)));
            step(0, 1, 1, 1, 0, 0);
        end
        drain(6);

        acc_cnt = 0;
        repeat (8) step(0, 1, 1, 0, 0, 0);
        chk("credit_fill", acc_cnt, 4);
        chk("credit_stall", imem_req_valid_o, 0);
        chk("credit_full", instr_valid_o, 1);
        acc_cnt = 0;
        step(0, 1, 1, 1, 0, 0);
        repeat (5) step(0, 1, 1, 0, 0, 0);
        chk("credit_one", acc_cnt, 1);
        drain(8);

        repeat (3) step(0, 1, 0, 1, 0, 0);
        step(0, 0, 0, 1, 1, 32'h0000_0102);
        for (int i = 0; i < 3; i++) begin
            chk("flush_noreq", imem_req_valid_o, 0);
            step(0, 0, 1, 1, 0, 0);
        end
        chk("redir_valid", imem_req_valid_o, 1);
        chk("redir_addr", imem_addr_o, 32'h100);
        chk("redir_empty", instr_valid_o, 0);
        step(0, 1, 1, 1, 0, 0);
        step(0, 0, 1, 1, 0, 0);
        chk("redir_head_valid", instr_valid_o, 1);
        chk("redir_head_pc", instr_pc_o, 32'h100);
        drain(6);

        repeat (3) step(0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        chk("same_cyc_head", instr_valid_o, 1);
        step(0, 0, 1, 1, 1, 32'h200);
        chk("same_cyc_empty", instr_valid_o, 0);
        chk("same_cyc_flush", imem_req_valid_o, 0);
        step(0, 0, 1, 1, 0, 0);
        chk("same_cyc_stale", instr_valid_o, 0);
        chk("same_cyc_addr", imem_addr_o, 32'h200);
        drain(6);

        step(0, 0, 0, 1, 1, 32'hFFFF_FFFC);
        chk("wrap_valid", imem_req_valid_o, 1);
        chk("wrap_top", imem_addr_o, 32'hFFFF_FFFC);
        step(0, 1, 1, 1, 0, 0);
        chk("wrap_zero", imem_addr_o, 32'h0);
        step(0, 0, 1, 1, 0, 0);
        chk("wrap_pc", instr_pc_o, 32'hFFFF_FFFC);
        drain(6);

        repeat (600) step(0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                          $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, $urandom);
        drain(8);

        repeat (2) step(0, 1, 0, 1, 0, 0);
        step(0, 0, 0, 1, 1, 32'h300);
        chk("pre_rst_flush", imem_req_valid_o, 0);
        start_i = 0; imem_req_ready_i = 0; imem_rsp_valid_i = 0;
        instr_ready_i = 0; redirect_i = 0;
        #2 rst = 1'b1;
        #1;
        chk("async_req_valid", imem_req_valid_o, 0);
        chk("async_instr_valid", instr_valid_o, 0);
        chk("async_addr", imem_addr_o, 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        repeat (3) step(0, 1, 1, 1, 1, 32'h40);
        chk("post_rst_idle", imem_req_valid_o, 0);
        step(1, 1, 1, 1, 0, 0);
        chk("post_rst_valid", imem_req_valid_o, 1);
        chk("post_rst_addr", imem_addr_o, 32'h0);
        repeat (6) step(0, 1, 1, 1, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
